// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, FSM states and field widths.
package fetch_pkg;

  localparam int unsigned INST_W = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: wrap-around pointers with an explicit occupancy count; flush empties it.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [INST_W-1:0] i_data,
  output logic [INST_W-1:0] o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CountMax = FIFO_DEPTH[CW-1:0];

  logic [INST_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push && (r_count != CountMax);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the count alone defines which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: program memory, pc, credit-based read issue and stream FSM.
// Optional build macro FETCH_NOP_SKIP_EN drops op==00 words at push.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = $clog2(IMEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_prog_we,
  input  logic [AW-1:0]     i_prog_addr,
  input  logic [INST_W-1:0] i_prog_data,
  input  logic              i_start,
  input  logic [AW:0]       i_prog_len,
  input  logic              i_flush,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0]  LenMax = IMEM_DEPTH[AW:0];
  localparam logic [FCW:0] OccMax = FIFO_DEPTH[FCW:0];

  fetch_state_e      r_state;
  fetch_state_e      w_state_d;
  logic [AW:0]       r_pc;
  logic [AW:0]       r_len;
  logic              r_rd_pend;
  logic [INST_W-1:0] r_rd_data;
  logic [INST_W-1:0] r_mem [IMEM_DEPTH];

  logic              w_start_ok;
  logic              w_we_ok;
  logic [AW:0]       w_len_clamped;
  logic [FCW:0]      w_occ;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [INST_W-1:0] w_head;
  logic [FCW-1:0]    w_count;
  logic              w_empty;

  assign w_start_ok    = (r_state == StIdle) && i_start && !i_flush;
  assign w_we_ok       = (r_state == StIdle) && i_prog_we;
  assign w_len_clamped = (i_prog_len > LenMax) ? LenMax : i_prog_len;

  // Words already in the FIFO plus the one in flight from memory must leave room.
  assign w_occ   = {1'b0, w_count} + {{FCW{1'b0}}, r_rd_pend};
  assign w_issue = (r_state == StFetch) && (r_pc < r_len) && (w_occ < OccMax) && !i_flush;

`ifdef FETCH_NOP_SKIP_EN
  assign w_push = r_rd_pend && (r_rd_data[7:6] != OP_NOP);
`else
  assign w_push = r_rd_pend;
`endif

  assign w_pop = o_inst_valid && i_inst_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_d = StFetch;
      StFetch: if (r_pc == r_len) w_state_d = StDrain;
      StDrain: if (w_empty && !r_rd_pend) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (i_flush) w_state_d = StIdle;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_len     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (i_flush) begin
        r_pc      <= '0;
        r_rd_pend <= 1'b0;
      end else begin
        r_rd_pend <= w_issue;
        if (w_start_ok) begin
          r_pc  <= '0;
          r_len <= w_len_clamped;
        end else if (w_issue) begin
          r_pc <= r_pc + {{AW{1'b0}}, 1'b1};
        end
      end
    end
  end

  // A write in the start cycle lands before the first read, which issues a cycle later.
  always_ff @(posedge i_clk) begin
    if (w_we_ok) r_mem[i_prog_addr] <= i_prog_data;
    if (w_issue) r_rd_data <= r_mem[r_pc[AW-1:0]];
  end

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(i_flush),
    .i_data (r_rd_data),
    .o_head (w_head),
    .o_count(w_count),
    .o_empty(w_empty)
  );

  assign o_inst_valid = !w_empty;
  assign o_inst       = o_inst_valid ? w_head : '0;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: cycle table for a basic stream plus stream/flush/reset sequences.
module tb_inst_fetch_unit;

  logic       clk;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic [4:0] prog_len;
  logic       flush;
  logic [7:0] inst;
  logic       inst_valid;
  logic       inst_ready;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_mem [16];

`ifdef FETCH_NOP_SKIP_EN
  localparam bit SkipNop = 1'b1;
`else
  localparam bit SkipNop = 1'b0;
`endif

  inst_fetch_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_prog_we   (prog_we),
    .i_prog_addr (prog_addr),
    .i_prog_data (prog_data),
    .i_start     (start),
    .i_prog_len  (prog_len),
    .i_flush     (flush),
    .o_inst      (inst),
    .o_inst_valid(inst_valid),
    .i_inst_ready(inst_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [4:0] len;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_inst;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Runs one stream and compares delivered words against the bench memory model.
  task automatic stream(input logic [4:0] len, input logic [3:0] rpat, input int hold,
                        input int wr_cyc, input logic [3:0] wr_addr, input logic [7:0] wr_data,
                        input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int ndone = 0;
    int unstable = 0;
    int nonzero = 0;
    bit stall = 1'b0;
    bit finished = 1'b0;
    logic [7:0] held = '0;
    int n;
    if (wr_cyc == 0) begin
      prog_we = 1'b1; prog_addr = wr_addr; prog_data = wr_data;
      model_mem[wr_addr] = wr_data;
    end
    n = (len > 5'd16) ? 16 : int'(len);
    for (int i = 0; i < n; i++) begin
      if (!(SkipNop && model_mem[i][7:6] == 2'b00)) exp_q.push_back(model_mem[i]);
    end
    start = 1'b1; prog_len = len; inst_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (stall && (!inst_valid || inst !== held)) unstable++;
      if (!inst_valid && inst !== 8'h00) nonzero++;
      if (done) ndone++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      inst_ready = (cyc < hold) ? 1'b0 : rpat[cyc % 4];
      start      = (cyc == 2);
      prog_len   = (cyc == 2) ? 5'd1 : len;
      prog_we    = (wr_cyc > 0 && cyc == wr_cyc);
      prog_addr  = wr_addr;
      prog_data  = wr_data;
      if (inst_valid && inst_ready) got_q.push_back(inst);
      stall = inst_valid && !inst_ready;
      held  = inst;
      @(posedge clk); #1;
    end
    start = 1'b0; prog_we = 1'b0; inst_ready = 1'b0;
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    check({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    check({tag, "_stall_stable"}, 32'(unstable), 32'd0);
    check({tag, "_inst_zero_when_invalid"}, 32'(nonzero), 32'd0);
  endtask

  initial begin
    vec_t vecs [8];
    int pops;
    int viol;
    logic [7:0] first_two [2];

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
    prog_len = '0; flush = 1'b0; inst_ready = 1'b0;
    #12;
    check("reset_inst", 32'(inst), 32'h00);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    prog_write(4'd0, 8'h41);
    prog_write(4'd1, 8'h82);
    prog_write(4'd2, 8'hC6);
    for (int i = 3; i < 16; i++) prog_write(4'(i), 8'h40 + 8'(i));

    // Basic stream with ready held high; start sampled at the first edge.
    vecs = '{
      '{1'b1, 5'd3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 5'd3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 5'd3, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0},
      '{1'b0, 5'd3, 1'b1, 1'b1, 8'h82, 1'b1, 1'b0},
      '{1'b0, 5'd3, 1'b1, 1'b1, 8'hC6, 1'b1, 1'b0},
      '{1'b0, 5'd3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 5'd3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1},
      '{1'b0, 5'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}
    };
    foreach (vecs[i]) begin
      start = vecs[i].start; prog_len = vecs[i].len; inst_ready = vecs[i].ready;
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_inst", i), 32'(inst), 32'(vecs[i].exp_inst));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
    end
    start = 1'b0; inst_ready = 1'b0;

    stream(5'd3, 4'b1001, 0, -1, 4'd0, 8'h00, "toggle");
    stream(5'd16, 4'b1111, 10, -1, 4'd0, 8'h00, "backpressure");
    stream(5'd31, 4'b0111, 0, -1, 4'd0, 8'h00, "clamp");
    stream(5'd0, 4'b1111, 0, -1, 4'd0, 8'h00, "len0");

    // Flush after two pops, then replay from address 0.
    start = 1'b1; prog_len = 5'd8; inst_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pops = 0;
    for (int c = 0; c < 50 && pops < 2; c++) begin
      if (inst_valid) begin
        first_two[pops] = inst;
        pops++;
      end
      @(posedge clk); #1;
    end
    check("flush_pops", 32'(pops), 32'd2);
    check("flush_pop0", 32'(first_two[0]), 32'h41);
    check("flush_pop1", 32'(first_two[1]), 32'h82);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; inst_ready = 1'b0;
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    viol = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || inst_valid || busy) viol++;
      @(posedge clk); #1;
    end
    check("flush_quiet", 32'(viol), 32'd0);
    stream(5'd8, 4'b1111, 0, -1, 4'd0, 8'h00, "replay");

    // Asynchronous reset mid-stream, asserted between edges.
    start = 1'b1; prog_len = 5'd16; inst_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("prerst_valid", 32'(inst_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_inst", 32'(inst), 32'h00);
    check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_valid", 32'(inst_valid), 32'd0);

    stream(5'd3, 4'b1111, 0, 1, 4'd1, 8'hFF, "we_busy");
    stream(5'd3, 4'b1111, 0, -1, 4'd0, 8'h00, "we_dropped");
    stream(5'd3, 4'b1111, 0, 0, 4'd0, 8'h55, "we_with_start");

    prog_write(4'd0, 8'h41);
    prog_write(4'd1, 8'h00);
    prog_write(4'd2, 8'h82);
    stream(5'd3, 4'b1111, 0, -1, 4'd0, 8'h00, "nop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
